// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit: mode encodings, per-level
// fill selection and small elaboration-time helpers.
package shift_pkg;

   typedef enum logic [2:0] {
      SHIFT_SLL  = 3'b000,
      SHIFT_SRL  = 3'b001,
      SHIFT_SRA  = 3'b010,
      SHIFT_ROL  = 3'b011,
      SHIFT_ROR  = 3'b100,
      SHIFT_PASS = 3'b101
   } shift_mode_e;

   typedef enum logic [1:0] {
      FILL_ZERO = 2'b00,
      FILL_SIGN = 2'b01,
      FILL_ROT  = 2'b10
   } fill_e;

   // Widest datapath bit_reverse can serve; callers size in and out with casts.
   localparam int unsigned MAXW = 256;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++)
         if ((32'd1 << i) < v) r = i + 1;
      return r;
   endfunction

   function automatic logic [MAXW-1:0] bit_reverse(input logic [MAXW-1:0] d,
                                                   input int unsigned     w);
      logic [MAXW-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < MAXW; i++)
         if (i < w) r[i] = d[w-1-i];
      return r;
   endfunction

endpackage

// File: rtl/shift_mux_level.sv
// One right-direction mux level of the barrel core: moves the word DIST places
// when enabled, filling with zeros, the captured sign, or the bits shifted out.
module shift_mux_level
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIST  = 1
) (
   input  logic [WIDTH-1:0] d,
   input  logic             en,
   input  fill_e            fill,
   input  logic             sign,
   output logic [WIDTH-1:0] q
);

   always_comb begin
      q = d;
      if (en) begin
         case (fill)
            FILL_ROT:  q = {d[DIST-1:0], d[WIDTH-1:DIST]};
            FILL_SIGN: q = {{DIST{sign}}, d[WIDTH-1:DIST]};
            default:   q = {{DIST{1'b0}}, d[WIDTH-1:DIST]};
         endcase
      end
   end

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined barrel shifter/rotator with valid/ready on both sides, tag
// pass-through and synchronous flush. Left modes reuse the right core via bit reversal.
module pipelined_shift_unit
   import shift_pkg::*;
#(
   parameter  int unsigned WIDTH     = 16,
   parameter  int unsigned REG_EVERY = 1,
   parameter  int unsigned TAGW      = 4,
   localparam int unsigned SHW       = clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_shamt,
   input  logic [2:0]       in_mode,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAGW-1:0]  out_tag
);

   localparam int unsigned L = SHW / REG_EVERY;

   logic             v_q      [L];
   logic [WIDTH-1:0] d_q      [L];
   logic [TAGW-1:0]  tag_q    [L];
   logic             rev_q    [L];
   logic [SHW-1:0]   sh_q     [L];
   fill_e            fill_q   [L];
   logic             sgn_q    [L];

   logic             ld       [L];
   logic             gin_v    [L];
   logic [WIDTH-1:0] gin_d    [L];
   logic [TAGW-1:0]  gin_tag  [L];
   logic             gin_rev  [L];
   logic [SHW-1:0]   gin_sh   [L];
   fill_e            gin_fill [L];
   logic             gin_sgn  [L];
   logic [WIDTH-1:0] gout_d   [L];

   logic             ent_rev;
   fill_e            ent_fill;
   logic [SHW-1:0]   ent_sh;
   logic [WIDTH-1:0] ent_d;
   logic             accept;

   // Pass-through modes zero the amount so every level leaves the data alone.
   always_comb begin
      ent_rev  = 1'b0;
      ent_fill = FILL_ZERO;
      ent_sh   = in_shamt;
      case (in_mode)
         SHIFT_SLL: ent_rev = 1'b1;
         SHIFT_SRL: ent_fill = FILL_ZERO;
         SHIFT_SRA: ent_fill = FILL_SIGN;
         SHIFT_ROL: begin
            ent_rev  = 1'b1;
            ent_fill = FILL_ROT;
         end
         SHIFT_ROR: ent_fill = FILL_ROT;
         default:   ent_sh = '0;
      endcase
      ent_d = ent_rev ? WIDTH'(bit_reverse(MAXW'(in_data), WIDTH)) : in_data;
   end

   // Ready chain: a stage may load if it is empty or everything ahead moves.
   always_comb begin
      for (int unsigned i = 0; i < L; i++) ld[i] = 1'b0;
      ld[L-1] = !v_q[L-1] || out_ready;
      for (int unsigned i = 1; i < L; i++)
         ld[L-1-i] = !v_q[L-1-i] || ld[L-i];
   end

   assign in_ready = ld[0] && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      gin_v[0]    = accept;
      gin_d[0]    = ent_d;
      gin_tag[0]  = in_tag;
      gin_rev[0]  = ent_rev;
      gin_sh[0]   = ent_sh;
      gin_fill[0] = ent_fill;
      gin_sgn[0]  = in_data[WIDTH-1];
      for (int unsigned k = 1; k < L; k++) begin
         gin_v[k]    = v_q[k-1];
         gin_d[k]    = d_q[k-1];
         gin_tag[k]  = tag_q[k-1];
         gin_rev[k]  = rev_q[k-1];
         gin_sh[k]   = sh_q[k-1];
         gin_fill[k] = fill_q[k-1];
         gin_sgn[k]  = sgn_q[k-1];
      end
   end

   // Each stage applies REG_EVERY levels; the amount is pre-shifted so bit 0
   // always steers the first level of the next group.
   for (genvar k = 0; k < L; k++) begin : g_grp
      logic [WIDTH-1:0] lv [REG_EVERY+1];
      assign lv[0] = gin_d[k];
      for (genvar j = 0; j < REG_EVERY; j++) begin : g_lvl
         shift_mux_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << (k*REG_EVERY + j))
         ) u_lvl (
            .d    (lv[j]),
            .en   (gin_sh[k][j]),
            .fill (gin_fill[k]),
            .sign (gin_sgn[k]),
            .q    (lv[j+1])
         );
      end
      assign gout_d[k] = lv[REG_EVERY];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < L; k++) begin
            v_q[k]    <= 1'b0;
            d_q[k]    <= '0;
            tag_q[k]  <= '0;
            rev_q[k]  <= 1'b0;
            sh_q[k]   <= '0;
            fill_q[k] <= FILL_ZERO;
            sgn_q[k]  <= 1'b0;
         end
      end else begin
         for (int unsigned k = 0; k < L; k++) begin
            if (flush)      v_q[k] <= 1'b0;
            else if (ld[k]) v_q[k] <= gin_v[k];
            if (ld[k]) begin
               d_q[k]    <= gout_d[k];
               tag_q[k]  <= gin_tag[k];
               rev_q[k]  <= gin_rev[k];
               sh_q[k]   <= gin_sh[k] >> REG_EVERY;
               fill_q[k] <= gin_fill[k];
               sgn_q[k]  <= gin_sgn[k];
            end
         end
      end
   end

   assign out_valid = v_q[L-1];
   assign out_tag   = tag_q[L-1];
   assign out_data  = rev_q[L-1] ? WIDTH'(bit_reverse(MAXW'(d_q[L-1]), WIDTH)) : d_q[L-1];

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Self-checking bench for pipelined_shift_unit (WIDTH=16, REG_EVERY=1, latency 4)
// against an in-order queue model with arithmetic shift/rotate reference.
module tb_pipelined_shift_unit;

   localparam int unsigned L = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_shamt;
   logic [2:0]  in_mode;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_tag;

   pipelined_shift_unit #(
      .WIDTH     (16),
      .REG_EVERY (1),
      .TAGW      (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic [3:0]  t;
      int unsigned a;
   } item_t;

   typedef struct packed {
      logic [2:0]  m;
      logic [15:0] d;
      logic [3:0]  s;
      logic [15:0] e;
   } vec_t;

   item_t       q[$];
   int unsigned now = 0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;
   logic        acc;

   vec_t dir [17] = '{
      '{3'd1, 16'h8001, 4'd1,  16'h4000},
      '{3'd0, 16'h0001, 4'd15, 16'h8000},
      '{3'd0, 16'hA5C3, 4'd0,  16'hA5C3},
      '{3'd1, 16'hA5C3, 4'd0,  16'hA5C3},
      '{3'd2, 16'hA5C3, 4'd0,  16'hA5C3},
      '{3'd3, 16'hA5C3, 4'd0,  16'hA5C3},
      '{3'd4, 16'hA5C3, 4'd0,  16'hA5C3},
      '{3'd5, 16'hA5C3, 4'd0,  16'hA5C3},
      '{3'd7, 16'hA5C3, 4'd0,  16'hA5C3},
      '{3'd4, 16'h1234, 4'd4,  16'h4123},
      '{3'd3, 16'h1234, 4'd4,  16'h2341},
      '{3'd4, 16'h8001, 4'd3,  16'h3000},
      '{3'd3, 16'h8001, 4'd1,  16'h0003},
      '{3'd2, 16'h8000, 4'd15, 16'hFFFF},
      '{3'd2, 16'h7FFF, 4'd15, 16'h0000},
      '{3'd2, 16'hF0F0, 4'd4,  16'hFF0F},
      '{3'd5, 16'h1234, 4'd7,  16'h1234}
   };

   function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] s,
                                             input logic [2:0] m);
      logic [31:0] dd;
      dd = {d, d};
      case (m)
         3'd0: return d << s;
         3'd1: return d >> s;
         3'd2: return $unsigned($signed(d) >>> s);
         3'd3: begin dd = dd << s; return dd[31:16]; end
         3'd4: begin dd = dd >> s; return dd[15:0]; end
         default: return d;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock cycle, entered and left at the falling edge.
   task automatic step(input logic iv, input logic [15:0] d, input logic [3:0] s,
                       input logic [2:0] m, input logic [3:0] tg, input logic [15:0] e,
                       input logic ordy, input logic fl, output logic accepted);
      logic exp_rdy, exp_ov;
      in_valid  = iv;
      in_data   = d;
      in_shamt  = s;
      in_mode   = m;
      in_tag    = tg;
      out_ready = ordy;
      flush     = fl;
      #1;
      exp_rdy = !fl && (q.size() < L || ordy);
      exp_ov  = (q.size() != 0) && (now + 1 >= q[0].a + L);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
         chk("out_data", 32'(out_data), 32'(q[0].d));
         chk("out_tag", 32'(out_tag), 32'(q[0].t));
      end
      accepted = iv && exp_rdy;
      if (fl) q.delete();
      else begin
         if (exp_ov && ordy) void'(q.pop_front());
         if (accepted) q.push_back('{d: e, t: tg, a: now + 1});
      end
      @(posedge clk);
      now++;
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 16'h0, 4'h0, 3'd0, 4'h0, 16'h0, ordy, 1'b0, acc);
   endtask

   task automatic drain();
      for (int unsigned i = 0; i < 40 && q.size() != 0; i++) idle(1'b1);
   endtask

   initial begin
      logic [15:0] bd [8];
      logic [3:0]  bs [8];
      logic [2:0]  bm [8];
      int unsigned idx;
      int unsigned cyc;
      logic [15:0] rd;
      logic [3:0]  rs;
      logic [2:0]  rm;

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      in_shamt = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_out_data", 32'(out_data), 32'd0);
      chk("reset_out_tag", 32'(out_tag), 32'd0);
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Isolated op shows the exact latency, then the rest back-to-back.
      step(1'b1, dir[0].d, dir[0].s, dir[0].m, 4'h0, dir[0].e, 1'b1, 1'b0, acc);
      for (int unsigned i = 0; i < 5; i++) idle(1'b1);
      for (int unsigned i = 1; i < 17; i++)
         step(1'b1, dir[i].d, dir[i].s, dir[i].m, 4'(i), dir[i].e, 1'b1, 1'b0, acc);
      drain();

      // Backpressure: tags 0..7, consumer stalls from cycle 2, releases at cycle 10.
      for (int unsigned i = 0; i < 8; i++) begin
         bd[i] = 16'($urandom);
         bs[i] = 4'($urandom);
         bm[i] = 3'($urandom_range(0, 4));
      end
      idx = 0;
      cyc = 0;
      while (idx < 8 && cyc < 40) begin
         step(1'b1, bd[idx], bs[idx], bm[idx], 4'(idx), ref_shift(bd[idx], bs[idx], bm[idx]),
              (cyc < 2) || (cyc >= 10), 1'b0, acc);
         if (acc) idx++;
         cyc++;
      end
      drain();

      // Flush with three ops in flight and a colliding request.
      for (int unsigned i = 0; i < 3; i++) begin
         rd = 16'($urandom);
         step(1'b1, rd, 4'd3, 3'd4, 4'(i), ref_shift(rd, 4'd3, 3'd4), 1'b1, 1'b0, acc);
      end
      step(1'b1, 16'h5555, 4'd2, 3'd1, 4'h9, 16'h1555, 1'b1, 1'b1, acc);
      for (int unsigned i = 0; i < 4; i++) idle(1'b1);
      step(1'b1, 16'h00F0, 4'd4, 3'd0, 4'hA, 16'h0F00, 1'b1, 1'b0, acc);
      drain();

      // Randomized traffic with stalls and occasional flushes.
      for (int unsigned i = 0; i < 120; i++) begin
         rd = 16'($urandom);
         rs = 4'($urandom);
         rm = 3'($urandom_range(0, 7));
         step(1'($urandom_range(0, 3) != 0), rd, rs, rm, 4'($urandom), ref_shift(rd, rs, rm),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0), acc);
      end
      drain();

      // Asynchronous reset while results are held at the output.
      for (int unsigned i = 0; i < 4; i++) begin
         rd = 16'($urandom) | 16'h0101;
         step(1'b1, rd, 4'd0, 3'd5, 4'(i + 1), rd, 1'b0, 1'b0, acc);
      end
      for (int unsigned i = 0; i < 3; i++) idle(1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_out_data", 32'(out_data), 32'd0);
      chk("async_out_tag", 32'(out_tag), 32'd0);
      q.delete();
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 16'h1234, 4'd4, 3'd4, 4'h6, 16'h4123, 1'b1, 1'b0, acc);
      for (int unsigned i = 0; i < 5; i++) idle(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
